// File: rtl/itch_stream_parser.sv
// itch_stream_parser: streaming ITCH order decoder.
// Takes one REG_WIDTH word per valid/ready beat (7 beats per message),
// assembles the order fields and presents each supported order once on a
// registered valid/ready output. Unsupported types and broken framing are
// dropped and counted in a saturating error counter.
// Optional feature: define PARSER_TIMESTAMP_EN to keep word 1 and expose it
// on o_timestamp; otherwise word 1 is discarded.
module itch_stream_parser #(
    parameter int REG_WIDTH = 32,
    parameter int SYM_W     = 2,
    parameter int QTY_W     = 16,
    parameter int ERR_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sop,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SYM_W-1:0]     o_stock_symbol,
    output logic [REG_WIDTH-1:0] o_order_id,
    output logic [REG_WIDTH-1:0] o_price,
    output logic [QTY_W-1:0]     o_quantity,
    output logic [1:0]           o_order_type,
    output logic                 o_trade_type,
    output logic [ERR_W-1:0]     o_err_cnt
`ifdef PARSER_TIMESTAMP_EN
    ,
    output logic [REG_WIDTH-1:0] o_timestamp
`endif
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;

    // Working copy of the message being assembled
    logic [1:0]           type_q, type_d;
    logic                 buy_q, buy_d;
    logic [REG_WIDTH-1:0] id_q, id_d;
    logic [QTY_W-1:0]     qty_q, qty_d;
    logic [SYM_W-1:0]     sym_q, sym_d;

    // Presented order, loaded only when a complete supported message lands
    logic                 valid_q, valid_d;
    logic [1:0]           out_type_q, out_type_d;
    logic                 out_buy_q, out_buy_d;
    logic [REG_WIDTH-1:0] out_id_q, out_id_d;
    logic [REG_WIDTH-1:0] out_price_q, out_price_d;
    logic [QTY_W-1:0]     out_qty_q, out_qty_d;
    logic [SYM_W-1:0]     out_sym_q, out_sym_d;

    logic [ERR_W-1:0]     err_q, err_d;

`ifdef PARSER_TIMESTAMP_EN
    logic [REG_WIDTH-1:0] ts_q, ts_d;
    logic [REG_WIDTH-1:0] out_ts_q, out_ts_d;
`endif

    logic beat;
    logic take_hdr;
    logic err_inc;

    assign o_ready = (state_q != HOLD) || i_ready;
    assign beat    = i_valid && o_ready;

    // Next-state, field capture and error accounting
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        buy_d       = buy_q;
        id_d        = id_q;
        qty_d       = qty_q;
        sym_d       = sym_q;
        valid_d     = valid_q;
        out_type_d  = out_type_q;
        out_buy_d   = out_buy_q;
        out_id_d    = out_id_q;
        out_price_d = out_price_q;
        out_qty_d   = out_qty_q;
        out_sym_d   = out_sym_q;
        err_d       = err_q;
`ifdef PARSER_TIMESTAMP_EN
        ts_d        = ts_q;
        out_ts_d    = out_ts_q;
`endif
        take_hdr    = 1'b0;
        err_inc     = 1'b0;

        case (state_q)
            HDR: begin
                if (beat) begin
                    if (i_sop) take_hdr = 1'b1;
                    else       err_inc  = 1'b1;
                end
            end
            BODY: begin
                if (beat) begin
                    if (i_sop) begin
                        // A new header cuts the partial message short
                        take_hdr = 1'b1;
                        err_inc  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        case (cnt_q)
`ifdef PARSER_TIMESTAMP_EN
                            3'd1: ts_d = i_data;
`endif
                            3'd2: id_d  = i_data;
                            3'd3: qty_d = QTY_W'(i_data);
                            // Symbol shifts in w4 then w5, keeping the low SYM_W bits of {w4,w5}
                            3'd4, 3'd5: sym_d = SYM_W'({sym_q, i_data});
                            3'd6: begin
                                cnt_d = 3'd0;
                                if (type_q != 2'b11) begin
                                    valid_d     = 1'b1;
                                    out_type_d  = type_q;
                                    out_buy_d   = buy_q;
                                    out_id_d    = id_q;
                                    out_qty_d   = qty_q;
                                    out_sym_d   = sym_q;
                                    out_price_d = i_data;
`ifdef PARSER_TIMESTAMP_EN
                                    out_ts_d    = ts_q;
`endif
                                    state_d     = HOLD;
                                end else begin
                                    err_inc = 1'b1;
                                    state_d = HDR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = HDR;
                    // The header of the next message may ride on the handshake cycle
                    if (beat) begin
                        if (i_sop) take_hdr = 1'b1;
                        else       err_inc  = 1'b1;
                    end
                end
            end
            default: state_d = HDR;
        endcase

        if (take_hdr) begin
            type_d  = i_data[1:0];
            buy_d   = i_data[16];
            cnt_d   = 3'd1;
            state_d = BODY;
        end

        if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    // State, working fields and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= HDR;
            cnt_q       <= 3'd0;
            type_q      <= 2'd0;
            buy_q       <= 1'b0;
            id_q        <= '0;
            qty_q       <= '0;
            sym_q       <= '0;
            valid_q     <= 1'b0;
            out_type_q  <= 2'd0;
            out_buy_q   <= 1'b0;
            out_id_q    <= '0;
            out_price_q <= '0;
            out_qty_q   <= '0;
            out_sym_q   <= '0;
            err_q       <= '0;
`ifdef PARSER_TIMESTAMP_EN
            ts_q        <= '0;
            out_ts_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            buy_q       <= buy_d;
            id_q        <= id_d;
            qty_q       <= qty_d;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            out_type_q  <= out_type_d;
            out_buy_q   <= out_buy_d;
            out_id_q    <= out_id_d;
            out_price_q <= out_price_d;
            out_qty_q   <= out_qty_d;
            out_sym_q   <= out_sym_d;
            err_q       <= err_d;
`ifdef PARSER_TIMESTAMP_EN
            ts_q        <= ts_d;
            out_ts_q    <= out_ts_d;
`endif
        end
    end

    assign o_valid        = valid_q;
    assign o_order_type   = out_type_q;
    assign o_trade_type   = out_buy_q;
    assign o_order_id     = out_id_q;
    assign o_price        = out_price_q;
    assign o_quantity     = out_qty_q;
    assign o_stock_symbol = out_sym_q;
    assign o_err_cnt      = err_q;
`ifdef PARSER_TIMESTAMP_EN
    assign o_timestamp    = out_ts_q;
`endif

endmodule

// File: doc/itch_stream_parser.md
# itch_stream_parser

Streaming successor to the register-bank ITCH parser. It accepts an ITCH order message one REG_WIDTH word per beat over a valid/ready handshake and assembles the decoded order fields. It presents each order once, on a registered valid/ready output towards the order book. It also drops messages with an unsupported type, resynchronises on a start-of-packet marker and counts protocol errors.

## Interface
- REG_WIDTH, 32: input word width; also width of order id and price.
- SYM_W, 2: stock symbol output width, 1..2*REG_WIDTH.
- QTY_W, 16: quantity output width, 1..REG_WIDTH.
- ERR_W, 8: error counter width.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_data  in  REG_WIDTH  message word.
- i_valid  in  1  i_data valid.
- i_sop  in  1  word is the first word (header) of a message; qualified by i_valid.
- o_ready  out  1  parser accepts the word this cycle.
- o_valid  out  1  decoded order valid.
- i_ready  in  1  downstream accepts the order.
- o_stock_symbol  out  SYM_W  stock symbol.
- o_order_id  out  REG_WIDTH  order number.
- o_price  out  REG_WIDTH  price.
- o_quantity  out  QTY_W  shares.
- o_order_type  out  2  00 add, 01 cancel, 10 execute.
- o_trade_type  out  1  1 = buy, 0 = sell.
- o_err_cnt  out  ERR_W  saturating protocol-error count.

## Operation
- A beat is the cycle with i_valid && o_ready. Each message is 7 beats, word index w0..w6:
  - w0 header: [1:0] order type, [16] buy/sell.
  - w1 timestamp.
  - w2 order id.
  - w3 shares; low QTY_W bits are kept.
  - w4 symbol high word, w5 symbol low word; symbol = {w4,w5}[SYM_W-1:0].
  - w6 price.
- States:
  - HDR: expect header.
  - BODY: 3-bit word counter 1..6.
  - HOLD: output pending.
- Transitions:
  - HDR: a beat with i_sop=1 captures the header → BODY, counter=1. A beat with i_sop=0 is discarded, err+1, stays in HDR.
  - BODY: each beat stores word[counter] and counter+1.
  - BODY, beat w6: supported type → HOLD with o_valid=1. Type 11 → HDR, no output, err+1.
  - BODY, beat with i_sop=1: the partial message is abandoned, err+1, and the word is taken as a new header (counter=1).
  - HOLD: o_valid stays 1 and all outputs stay stable until i_ready. i_ready=1 → o_valid=0. If the same cycle carries a header beat, the header is captured and the next state is BODY; otherwise HDR.
- o_ready = (state != HOLD) || i_ready, combinational from state and i_ready.
- o_err_cnt saturates at all-ones and never wraps.
- Reset, including mid-message: state HDR, counter 0, o_valid 0, all data outputs 0, o_err_cnt 0. The partial message is lost. o_ready = 1 in the first cycle after reset.

## Timing
- Input-to-output latency: o_valid rises on the clock edge that accepts w6 and is visible the following cycle.
- Throughput: with i_ready held high, one message per 7 cycles with no bubble; the header beat overlaps the output handshake.
- Backpressure: o_ready=0 only in HOLD with i_ready=0. The source must hold i_data, i_valid and i_sop until accepted.
- All outputs are registered. o_ready is the only combinational output.

## Configuration
- PARSER_TIMESTAMP_EN defined:
  - Adds output o_timestamp (REG_WIDTH), loaded from w1.
  - o_timestamp is registered and updated with the other fields, and is reset to 0.
- Not defined:
  - Port absent, w1 discarded, no storage for it.

## Test plan
- Add order: w0=0x0001_0000, w2=0x03BA, w3=0x01BB, w4=0, w5=0x2341, w6=0xBABB, i_ready=1.
  - Response: one o_valid pulse 1 cycle after w6 with order_type 00, trade_type 1, id 0x03BA, qty 0x01BB, symbol 2'b01, price 0xBABB.
- Two back-to-back messages with i_ready=1 → o_valid at cycles 7 and 14 after the first header; o_ready never drops.
- i_ready=0 for 5 cycles after o_valid → outputs stable, o_ready=0, the next header stalls. On i_ready=1 the header is accepted in the same cycle.
- Header type 11 followed by 6 words → no o_valid, o_err_cnt 0→1.
- i_sop=1 on w3 of a message, followed by a full valid message → exactly one output (the second message), o_err_cnt +1.
- Mid-message faults, err saturation and reset:
  - Assert i_rst during w4 → o_valid=0 and o_err_cnt=0. A subsequent clean message decodes correctly.
  - With ERR_W=2, 5 stray non-sop beats in HDR → o_err_cnt stops at 3.
